// File: rtl/pipe_run_controller_pkg.sv
// Shared definitions for the pipeline run controller and the pipeline
// generator that instantiates it.
//   state_e        : 2-bit run FSM encoding (IDLE, ISSUE, DRAIN, DONE)
//   DEF_LATENCY    : default pipeline depth in non-stalled cycles
//   DEF_ITER_W     : default width of iteration count / issue index
//   DEF_OUT_W      : default width of the outstanding-result counter
package pipe_run_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_LATENCY = 32;
  localparam int DEF_ITER_W  = 16;
  localparam int DEF_OUT_W   = 6;

endpackage

// File: rtl/valid_shift_pipe.sv
// Stall-gated valid shift register that tracks which pipeline stages hold
// a live operand.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears every stage
//   en   : shift enable (low while the pipeline is stalled)
//   din  : valid bit entering stage 0
//   dout : valid bit of the last stage (DEPTH-1)
module valid_shift_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vp_q;
  logic [DEPTH-1:0] vp_d;

  // A single-stage pipe has no lower stages to shift from.
  generate
    if (DEPTH == 1) begin : g_single
      assign vp_d = din;
    end else begin : g_multi
      assign vp_d = {vp_q[DEPTH-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vp_q <= '0;
    end else if (en) begin
      vp_q <= vp_d;
    end
  end

  assign dout = vp_q[DEPTH-1];

endmodule

// File: rtl/pipe_run_controller.sv
// Sequences one run of a fixed-latency, stallable pipeline: issues `iters`
// operands one per non-stalled cycle, tracks them with a valid shift pipe
// and an outstanding counter, and pulses done after the last result leaves.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset (aborts any run)
//   start        : run request, sampled only in IDLE
//   iters        : operand count, latched with start
//   stall        : global stall, freezes issue, valid pipe and counters
//   busy         : high in ISSUE and DRAIN
//   issue        : operand enters the datapath this cycle
//   issue_idx    : index of the operand being issued
//   result_valid : pipeline output stage holds a valid result
//   done         : one-cycle pulse at the end of a run
// Handshake: there is no backpressure. An operand is transferred when issue
// is high; a result is consumed when result_valid is high and stall is low.
module pipe_run_controller
  import pipe_run_controller_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ITER_W  = DEF_ITER_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic              stall,
  output logic              busy,
  output logic              issue,
  output logic [ITER_W-1:0] issue_idx,
  output logic              result_valid,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              consume;
  logic              last_issue;

  assign issue      = (state_q == ST_ISSUE) && !stall;
  assign consume    = result_valid && !stall;
  // Compare against the latched count so iters may be all-ones.
  assign last_issue = issue && (idx_q == (iters_q - ITER_W'(1)));

  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (iters != '0) begin
            iters_d = iters;
            idx_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          idx_d = idx_q + ITER_W'(1);
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A zero count here means every result already left while issuing.
        if ((out_q == '0) || ((out_q == OUT_W'(1)) && consume)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case ({issue, consume})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iters_q <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      iters_q <= iters_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  valid_shift_pipe #(
    .DEPTH (LATENCY)
  ) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .en   (!stall),
    .din  (issue),
    .dout (result_valid)
  );

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign issue_idx = (state_q == ST_ISSUE) ? idx_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(issue && !consume && (out_q == OUT_W'(LATENCY))));
      assert (!(consume && !issue && (out_q == '0)));
    end
  end

endmodule

// File: tb/tb_pipe_run_controller.sv
module tb_pipe_run_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // DUT with LATENCY=4
  logic        start4 = 1'b0, stall4 = 1'b0;
  logic [15:0] iters4 = '0;
  logic        busy4, issue4, rv4, done4;
  logic [15:0] idx4;

  pipe_run_controller #(.LATENCY(4), .ITER_W(16), .OUT_W(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .iters(iters4), .stall(stall4),
    .busy(busy4), .issue(issue4), .issue_idx(idx4),
    .result_valid(rv4), .done(done4)
  );

  // DUT with LATENCY=1 and a narrow index for the all-ones count boundary
  logic        start1 = 1'b0, stall1 = 1'b0;
  logic [2:0]  iters1 = '0;
  logic        busy1, issue1, rv1, done1;
  logic [2:0]  idx1;

  pipe_run_controller #(.LATENCY(1), .ITER_W(3), .OUT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .iters(iters1), .stall(stall1),
    .busy(busy1), .issue(issue1), .issue_idx(idx1),
    .result_valid(rv1), .done(done1)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs, check that cycle's outputs, then advance.
  task automatic c4(input string tag, input logic s, input logic [15:0] n, input logic sl,
                    input logic eb, input logic ei, input logic [15:0] ex,
                    input logic erv, input logic ed);
    start4 = s; iters4 = n; stall4 = sl;
    #1;
    chk({tag, ".busy"}, 16'(busy4), 16'(eb));
    chk({tag, ".issue"}, 16'(issue4), 16'(ei));
    if (ei) chk({tag, ".idx"}, idx4, ex);
    chk({tag, ".rv"}, 16'(rv4), 16'(erv));
    chk({tag, ".done"}, 16'(done4), 16'(ed));
    @(posedge clk); #1;
    start4 = 1'b0; stall4 = 1'b0;
  endtask

  task automatic c1(input string tag, input logic s, input logic [2:0] n, input logic sl,
                    input logic eb, input logic ei, input logic [2:0] ex,
                    input logic erv, input logic ed);
    start1 = s; iters1 = n; stall1 = sl;
    #1;
    chk({tag, ".busy"}, 16'(busy1), 16'(eb));
    chk({tag, ".issue"}, 16'(issue1), 16'(ei));
    if (ei) chk({tag, ".idx"}, 16'(idx1), 16'(ex));
    chk({tag, ".rv"}, 16'(rv1), 16'(erv));
    chk({tag, ".done"}, 16'(done1), 16'(ed));
    @(posedge clk); #1;
    start1 = 1'b0; stall1 = 1'b0;
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, ".busy"}, 16'(busy4), 16'd0);
    chk({tag, ".issue"}, 16'(issue4), 16'd0);
    chk({tag, ".idx"}, idx4, 16'd0);
    chk({tag, ".rv"}, 16'(rv4), 16'd0);
    chk({tag, ".done"}, 16'(done4), 16'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero4("rst4");
    chk("rst1.busy", 16'(busy1), 16'd0);
    chk("rst1.rv", 16'(rv1), 16'd0);
    chk("rst1.done", 16'(done1), 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: iters=3, no stall
    c4("t1c0", 1, 3, 0, 0, 0, 0, 0, 0);
    c4("t1c1", 0, 0, 0, 1, 1, 0, 0, 0);
    c4("t1c2", 0, 0, 0, 1, 1, 1, 0, 0);
    c4("t1c3", 0, 0, 0, 1, 1, 2, 0, 0);
    c4("t1c4", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t1c5", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t1c6", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t1c7", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t1c8", 0, 0, 0, 0, 0, 0, 0, 1);
    c4("t1c9", 0, 0, 0, 0, 0, 0, 0, 0);

    // T2: iters=3, stall at cycles 2 and 6
    c4("t2c0", 1, 3, 0, 0, 0, 0, 0, 0);
    c4("t2c1", 0, 0, 0, 1, 1, 0, 0, 0);
    c4("t2c2", 0, 0, 1, 1, 0, 0, 0, 0);
    c4("t2c3", 0, 0, 0, 1, 1, 1, 0, 0);
    c4("t2c4", 0, 0, 0, 1, 1, 2, 0, 0);
    c4("t2c5", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t2c6", 0, 0, 1, 1, 0, 0, 1, 0);
    c4("t2c7", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t2c8", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t2c9", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t2c10", 0, 0, 0, 0, 0, 0, 0, 1);
    c4("t2c11", 0, 0, 0, 0, 0, 0, 0, 0);

    // T3: iters=0 with stall held high; done is not extended
    c4("t3c0", 1, 0, 1, 0, 0, 0, 0, 0);
    c4("t3c1", 0, 0, 1, 0, 0, 0, 0, 1);
    c4("t3c2", 0, 0, 1, 0, 0, 0, 0, 0);

    // T4: second start during ISSUE is ignored
    c4("t4c0", 1, 3, 0, 0, 0, 0, 0, 0);
    c4("t4c1", 0, 0, 0, 1, 1, 0, 0, 0);
    c4("t4c2", 1, 7, 0, 1, 1, 1, 0, 0);
    c4("t4c3", 0, 0, 0, 1, 1, 2, 0, 0);
    c4("t4c4", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t4c5", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t4c6", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t4c7", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t4c8", 0, 0, 0, 0, 0, 0, 0, 1);
    c4("t4c9", 0, 0, 0, 0, 0, 0, 0, 0);

    // T5: reset mid-DRAIN with two results in flight
    c4("t5c0", 1, 3, 0, 0, 0, 0, 0, 0);
    c4("t5c1", 0, 0, 0, 1, 1, 0, 0, 0);
    c4("t5c2", 0, 0, 0, 1, 1, 1, 0, 0);
    c4("t5c3", 0, 0, 0, 1, 1, 2, 0, 0);
    c4("t5c4", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t5c5", 0, 0, 0, 1, 0, 0, 1, 0);
    rst = 1'b0;
    #1;
    chk_zero4("t5rst_now");
    @(posedge clk); #1;
    chk_zero4("t5rst_held");
    rst = 1'b1;
    c4("t5idle0", 0, 0, 0, 0, 0, 0, 0, 0);
    c4("t5idle1", 0, 0, 0, 0, 0, 0, 0, 0);
    c4("t5idle2", 0, 0, 0, 0, 0, 0, 0, 0);
    c4("t5r0", 1, 1, 0, 0, 0, 0, 0, 0);
    c4("t5r1", 0, 0, 0, 1, 1, 0, 0, 0);
    c4("t5r2", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t5r3", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t5r4", 0, 0, 0, 1, 0, 0, 0, 0);
    c4("t5r5", 0, 0, 0, 1, 0, 0, 1, 0);
    c4("t5r6", 0, 0, 0, 0, 0, 0, 0, 1);
    c4("t5r7", 0, 0, 0, 0, 0, 0, 0, 0);

    // T6: LATENCY=1, iters=5, no stall
    c1("t6c0", 1, 3'd5, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      c1($sformatf("t6c%0d", i), 0, 0, 0, 1, 1, 3'(i - 1), (i >= 2), 0);
    c1("t6c6", 0, 0, 0, 1, 0, 0, 1, 0);
    c1("t6c7", 0, 0, 0, 0, 0, 0, 0, 1);
    c1("t6c8", 0, 0, 0, 0, 0, 0, 0, 0);

    // T7: LATENCY=1, all-ones count (iters=7 on a 3-bit index), back-to-back
    c1("t7c0", 1, 3'd7, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      c1($sformatf("t7c%0d", i), 0, 0, 0, 1, 1, 3'(i - 1), (i >= 2), 0);
    c1("t7c8", 0, 0, 0, 1, 0, 0, 1, 0);
    c1("t7c9", 0, 0, 0, 0, 0, 0, 0, 1);
    c1("t7c10", 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
